// File: rtl/snn_aer_pkg.sv
// Shared types for the post-synaptic spike AER encoder.
// Optional feature macro: SNN_AER_TSTEP_TAG_EN (per-entry timestep tag storage).
package snn_aer_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int TS_W_DEF   = 8;

  // Serializer states
  // state   | meaning
  // S_EMPTY | no group loaded, waiting for the FIFO to become non-empty
  // S_EMIT  | group loaded, presenting one AER word per set mask bit
  typedef enum logic {
    S_EMPTY = 1'b0,
    S_EMIT  = 1'b1
  } ser_state_t;

  // Group entry layout at default widths: 4-aligned base, spike mask, tag.
  typedef struct packed {
    logic [ADDR_W_DEF-3:0] base;
    logic [3:0]            mask;
`ifdef SNN_AER_TSTEP_TAG_EN
    logic [TS_W_DEF-1:0]   tstep;
`endif
  } grp_entry_t;

  // Index of the lowest set bit; result for an all-zero mask is don't-care.
  function automatic logic [1:0] lsb4(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

endpackage

// File: rtl/spike_grp_fifo.sv
// Synchronous group FIFO with head-valid read data (head is visible while
// not empty). A push into a full FIFO is accepted only when a pop happens in
// the same cycle. Entries pushed this cycle are never bypassed to the head.
module spike_grp_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/post_spike_aer_encoder.sv
// Buffers non-empty 4-neuron spike groups from the post-synaptic core and
// serializes them into one AER word per spiking neuron (valid/ready).
// Optional feature macro: SNN_AER_TSTEP_TAG_EN -- when defined, the timestep
// is stored per entry and driven on AER_TSTEP; otherwise AER_TSTEP is 0.
module post_spike_aer_encoder
  import snn_aer_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int TS_W       = TS_W_DEF,
  parameter int CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLR,
  input  logic              EVT_VALID,
  input  logic [3:0]        EVT_SPIKES,
  input  logic [ADDR_W-1:0] EVT_BASE_ADDR,
  input  logic [TS_W-1:0]   TSTEP_IN,
  output logic              AER_VALID,
  input  logic              AER_READY,
  output logic [ADDR_W-1:0] AER_ADDR,
  output logic [TS_W-1:0]   AER_TSTEP,
  output logic              BUSY,
  output logic              OVF,
  output logic [CNT_W-1:0]  DROP_CNT,
  output logic [CNT_W-1:0]  SPK_CNT
);

  localparam int BASE_W = ADDR_W - 2;

  typedef struct packed {
    logic [BASE_W-1:0] base;
    logic [3:0]        mask;
`ifdef SNN_AER_TSTEP_TAG_EN
    logic [TS_W-1:0]   tstep;
`endif
  } entry_t;

  entry_t                    push_entry;
  entry_t                    head;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  ser_state_t                state;
  logic [3:0]                mask;
  logic [BASE_W-1:0]         base;
  logic                      valid_r;
  logic [ADDR_W-1:0]         addr_r;
  logic [3:0]                mask_left;
  logic                      clear;
  logic                      hs;
  logic                      last;
  logic                      pop;
  logic                      push_req;
  logic                      drop;

`ifdef SNN_AER_TSTEP_TAG_EN
  logic [TS_W-1:0]           tstep_r;
  logic                      unused_bits;
  assign unused_bits = ^EVT_BASE_ADDR[1:0];
  assign AER_TSTEP   = tstep_r;
`else
  logic                      unused_bits;
  assign unused_bits = ^{EVT_BASE_ADDR[1:0], TSTEP_IN};
  assign AER_TSTEP   = '0;
`endif

  assign clear     = RST || CLR;
  assign hs        = valid_r && AER_READY;
  // Mask with the bit currently on the bus removed.
  assign mask_left = mask & ~(4'b0001 << addr_r[1:0]);
  assign last      = hs && (mask_left == '0);
  // Load a new group when idle, or back-to-back when the current one finishes.
  assign pop       = !fifo_empty && ((state == S_EMPTY) || last);
  assign push_req  = EVT_VALID && (EVT_SPIKES != '0);
  assign drop      = push_req && fifo_full && !pop;

  assign AER_VALID = valid_r;
  assign AER_ADDR  = addr_r;
  assign BUSY      = (fifo_count != '0) || (state == S_EMIT);

  // Pack the incoming group; address low bits are dropped (4-aligned groups).
  always_comb begin
    push_entry      = '0;
    push_entry.base = EVT_BASE_ADDR[ADDR_W-1:2];
    push_entry.mask = EVT_SPIKES;
`ifdef SNN_AER_TSTEP_TAG_EN
    push_entry.tstep = TSTEP_IN;
`endif
  end

  spike_grp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .clr       (CLR),
    .push      (push_req),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Serializer FSM with registered AER outputs.
  always_ff @(posedge CLK) begin
    if (clear) begin
      state   <= S_EMPTY;
      mask    <= '0;
      base    <= '0;
      valid_r <= 1'b0;
      addr_r  <= '0;
`ifdef SNN_AER_TSTEP_TAG_EN
      tstep_r <= '0;
`endif
    end else if (pop) begin
      state   <= S_EMIT;
      mask    <= head.mask;
      base    <= head.base;
      valid_r <= 1'b1;
      addr_r  <= {head.base, lsb4(head.mask)};
`ifdef SNN_AER_TSTEP_TAG_EN
      tstep_r <= head.tstep;
`endif
    end else if (hs && (mask_left != '0)) begin
      mask    <= mask_left;
      addr_r  <= {base, lsb4(mask_left)};
    end else if (hs) begin
      state   <= S_EMPTY;
      mask    <= '0;
      valid_r <= 1'b0;
    end
  end

  // Saturating statistics and sticky overflow flag.
  always_ff @(posedge CLK) begin
    if (clear) begin
      SPK_CNT  <= '0;
      DROP_CNT <= '0;
      OVF      <= 1'b0;
    end else begin
      if (hs && (SPK_CNT != '1)) SPK_CNT <= SPK_CNT + CNT_W'(1);
      if (drop) begin
        OVF <= 1'b1;
        if (DROP_CNT != '1) DROP_CNT <= DROP_CNT + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_post_spike_aer_encoder.sv
// Scoreboard bench for post_spike_aer_encoder: stimulus pushes expected AER
// words into a queue, a negedge monitor compares whatever the DUT presents.
module tb_post_spike_aer_encoder;

  localparam int ADDR_W = 10;
  localparam int TS_W   = 8;
  localparam int CNT_W  = 16;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst, clr, evt_valid, aer_ready;
  logic [3:0]        evt_spikes;
  logic [ADDR_W-1:0] evt_base;
  logic [TS_W-1:0]   tstep_in;
  logic              aer_valid, busy, ovf;
  logic [ADDR_W-1:0] aer_addr;
  logic [TS_W-1:0]   aer_tstep;
  logic [CNT_W-1:0]  drop_cnt, spk_cnt;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [TS_W-1:0]   ts;
  } word_t;

  word_t exp_q[$];
  int    n_pass  = 0;
  int    n_total = 0;

  always #5 clk = ~clk;

  post_spike_aer_encoder #(
    .FIFO_DEPTH (DEPTH),
    .ADDR_W     (ADDR_W),
    .TS_W       (TS_W),
    .CNT_W      (CNT_W)
  ) dut (
    .CLK           (clk),
    .RST           (rst),
    .CLR           (clr),
    .EVT_VALID     (evt_valid),
    .EVT_SPIKES    (evt_spikes),
    .EVT_BASE_ADDR (evt_base),
    .TSTEP_IN      (tstep_in),
    .AER_VALID     (aer_valid),
    .AER_READY     (aer_ready),
    .AER_ADDR      (aer_addr),
    .AER_TSTEP     (aer_tstep),
    .BUSY          (busy),
    .OVF           (ovf),
    .DROP_CNT      (drop_cnt),
    .SPK_CNT       (spk_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [TS_W-1:0] tag(input logic [TS_W-1:0] t);
`ifdef SNN_AER_TSTEP_TAG_EN
    return t;
`else
    return '0;
`endif
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one strobe for one cycle; queue its words if the bench expects it stored.
  task automatic strobe(input logic [ADDR_W-1:0] base, input logic [3:0] spk,
                        input logic [TS_W-1:0] ts, input bit accepted);
    evt_valid  = 1'b1;
    evt_base   = base;
    evt_spikes = spk;
    tstep_in   = ts;
    if (accepted) begin
      for (int i = 0; i < 4; i++)
        if (spk[i]) exp_q.push_back({base[ADDR_W-1:2], 2'(i), tag(ts)});
    end
    step(1);
    evt_valid  = 1'b0;
    evt_spikes = '0;
  endtask

  task automatic wait_drain(input int max_cycles);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < max_cycles) begin
      step(1);
      k++;
    end
    check("drain_queue_left", 64'(exp_q.size()), 0);
    check("drain_busy", 64'(busy), 0);
  endtask

  // Monitor: every presented word must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && !clr && aer_valid) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_word: got addr 0x%0h, expected no word", aer_addr);
      end else begin
        check("aer_addr", 64'(aer_addr), 64'(exp_q[0].addr));
        check("aer_tstep", 64'(aer_tstep), 64'(exp_q[0].ts));
        if (aer_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clr = 1'b0; evt_valid = 1'b0; evt_spikes = '0;
    evt_base = '0; tstep_in = '0; aer_ready = 1'b0;
    step(3);
    check("rst_valid", 64'(aer_valid), 0);
    check("rst_addr", 64'(aer_addr), 0);
    check("rst_tstep", 64'(aer_tstep), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_ovf", 64'(ovf), 0);
    check("rst_drop", 64'(drop_cnt), 0);
    check("rst_spk", 64'(spk_cnt), 0);
    rst = 1'b0;
    step(1);

    // Single group with latency check.
    aer_ready = 1'b1;
    strobe(10'h0C8, 4'b1010, 8'd5, 1'b1);
    check("lat_n1_valid", 64'(aer_valid), 0);
    step(1);
    check("lat_n2_valid", 64'(aer_valid), 1);
    wait_drain(50);
    check("single_spk_cnt", 64'(spk_cnt), 2);

    // Back-to-back groups, nonzero low address bits ignored, zero mask ignored.
    strobe(10'h002, 4'b1111, 8'd1, 1'b1);
    strobe(10'h005, 4'b0001, 8'd2, 1'b1);
    strobe(10'h00B, 4'b0000, 8'd3, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check("b2b_no_bubble", 64'(aer_valid), 1);
      step(1);
    end
    check("b2b_valid_end", 64'(aer_valid), 0);
    check("b2b_busy_end", 64'(busy), 0);
    check("b2b_spk_cnt", 64'(spk_cnt), 7);

    // Backpressure mid-group.
    strobe(10'h020, 4'b1111, 8'd9, 1'b1);
    step(2);
    aer_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check("stall_valid", 64'(aer_valid), 1);
      check("stall_addr", 64'(aer_addr), 64'h021);
      step(1);
    end
    aer_ready = 1'b1;
    wait_drain(50);
    check("bp_spk_cnt", 64'(spk_cnt), 11);

    // Overflow: serializer held, then 18 strobes into a 16-deep FIFO.
    aer_ready = 1'b0;
    strobe(10'h100, 4'b0100, 8'h20, 1'b1);
    step(2);
    for (int i = 0; i < 18; i++)
      strobe(ADDR_W'(32'h200 + 4 * i), 4'(1 << (i % 4)), TS_W'(i), i < 16);
    check("ovf_drop_cnt", 64'(drop_cnt), 2);
    check("ovf_flag", 64'(ovf), 1);
    check("ovf_busy", 64'(busy), 1);
    check("ovf_valid_held", 64'(aer_valid), 1);
    // Full FIFO: push coincides with the pop of the next group.
    aer_ready = 1'b1;
    strobe(10'h300, 4'b1000, 8'h77, 1'b1);
    check("full_pushpop_drop", 64'(drop_cnt), 2);
    wait_drain(100);
    check("ovf_spk_cnt", 64'(spk_cnt), 29);

    // Soft clear mid-emit with three groups queued.
    aer_ready = 1'b0;
    strobe(10'h040, 4'b0011, 8'd1, 1'b1);
    strobe(10'h080, 4'b0001, 8'd2, 1'b1);
    strobe(10'h0C0, 4'b0001, 8'd3, 1'b1);
    strobe(10'h0F0, 4'b0001, 8'd4, 1'b1);
    step(1);
    check("pre_clr_valid", 64'(aer_valid), 1);
    clr = 1'b1;
    exp_q.delete();
    step(1);
    clr = 1'b0;
    check("clr_valid", 64'(aer_valid), 0);
    check("clr_busy", 64'(busy), 0);
    check("clr_addr", 64'(aer_addr), 0);
    check("clr_spk_cnt", 64'(spk_cnt), 0);
    check("clr_drop_cnt", 64'(drop_cnt), 0);
    check("clr_ovf", 64'(ovf), 0);
    aer_ready = 1'b1;
    step(10);
    check("clr_busy_after", 64'(busy), 0);

    // RST and CLR together mid-group.
    aer_ready = 1'b0;
    strobe(10'h3F0, 4'b1100, 8'd6, 1'b1);
    step(2);
    rst = 1'b1;
    clr = 1'b1;
    exp_q.delete();
    step(1);
    rst = 1'b0;
    clr = 1'b0;
    check("rstclr_valid", 64'(aer_valid), 0);
    check("rstclr_busy", 64'(busy), 0);
    aer_ready = 1'b1;
    step(5);
    check("rstclr_spk_cnt", 64'(spk_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/post_spike_aer_encoder.md
Name: post_spike_aer_encoder

Overview:
- Sits directly downstream of the post-synaptic neuron core and consumes its 4-bit NEUR_EVENT_OUT group strobes.
- Each strobe covers 4 post-neurons at one 4-aligned address. Strobes arrive up to once per cycle.
- Non-empty groups are buffered in a FIFO. The block then serializes them into one Address-Event (AER) word per spiking neuron on a valid/ready output channel, feeding the spike output/readout path.

Parameters:
- FIFO_DEPTH, 16, number of group entries; power of two, at least 2.
- ADDR_W, 10, post-neuron address width.
- TS_W, 8, timestep tag width.
- CNT_W, 16, width of the statistics counters.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- CLR  in  1  synchronous soft clear of FIFO, serializer, counters and OVF; same effect as RST.
- EVT_VALID  in  1  group strobe; core drives it as POST_NEUR_CS && POST_NEUR_WE.
- EVT_SPIKES  in  4  per-neuron spike flags; bit i is neuron EVT_BASE_ADDR+i.
- EVT_BASE_ADDR  in  ADDR_W  group address; bits [1:0] are ignored and treated as 0.
- TSTEP_IN  in  TS_W  current timestep index, sampled with EVT_VALID.
- AER_VALID  out  1  output word valid.
- AER_READY  in  1  consumer ready.
- AER_ADDR  out  ADDR_W  spiking neuron address.
- AER_TSTEP  out  TS_W  timestep tag.
- BUSY  out  1  FIFO non-empty or serializer loaded.
- OVF  out  1  sticky; set on any dropped group.
- DROP_CNT  out  CNT_W  dropped groups; saturates at all-ones.
- SPK_CNT  out  CNT_W  AER words accepted; saturates at all-ones.

Behaviour:
- Reset/CLR values: AER_VALID=0, AER_ADDR=0, AER_TSTEP=0, BUSY=0, OVF=0, DROP_CNT=0, SPK_CNT=0. FIFO becomes empty and the serializer becomes empty. Any in-flight words are discarded; this applies mid-serialization as well.
- Push rule:
  - A push occurs when EVT_VALID=1 and EVT_SPIKES!=0.
  - A group with EVT_SPIKES==0 is ignored and is not counted.
  - Entry format: {EVT_BASE_ADDR[ADDR_W-1:2], EVT_SPIKES, TSTEP_IN}.
- Full FIFO:
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the push is dropped: DROP_CNT increments and OVF is set.
- Serializer FSM has two states, EMPTY and EMIT, and holds a mask register and a base register.
  - EMPTY: if the FIFO is non-empty, pop the head, load mask and base, go to EMIT.
  - EMIT: AER_VALID=1. AER_ADDR = {base, idx}, where idx is the lowest set bit of the mask. AER_TSTEP = the entry's tag.
  - On AER_VALID && AER_READY: clear that mask bit and increment SPK_CNT.
  - When the cleared bit was the last one set: if the FIFO is non-empty, pop the next entry in the same cycle and stay in EMIT (zero bubble). Otherwise go to EMPTY.
- Output rules:
  - While AER_VALID=1 and AER_READY=0, AER_ADDR and AER_TSTEP hold stable.
  - AER_VALID never drops without a handshake, except on RST or CLR.
- Latency: a strobe at cycle N is written to the FIFO at edge N. With the FIFO previously empty, AER_VALID=1 from cycle N+2.
- Ordering: groups leave in arrival order. Within a group, the lowest index goes first.
- Throughput: one AER word per cycle while AER_READY=1.
- Simultaneous push and pop on an empty FIFO: the pushed entry is not bypassed. It is popped at the earliest on the next cycle.
- BUSY = (FIFO count != 0) || (state == EMIT).
- RST and CLR are both active in the same cycle: identical result.

Optional Feature:
- SNN_AER_TSTEP_TAG_EN
  - Defined: the timestep is stored per entry and driven on AER_TSTEP.
  - Undefined: the TS_W field is removed from the FIFO storage and AER_TSTEP is tied to 0. TSTEP_IN is ignored. All other behaviour is unchanged.

Decomposition:
- Package snn_aer_pkg:
  - ADDR_W and TS_W defaults.
  - The group-entry typedef, as a packed struct of base, mask and tstep.
  - The serializer state enum.
  - A lowest-set-bit function for 4 bits.
- Sub-module spike_grp_fifo:
  - Synchronous FIFO with push, pop, full, empty and count.
  - Read data is registered/head-valid.
  - Synchronous clear.

Test Plan:
- Single group: EVT_SPIKES=4'b1010, base=0x0C8, TSTEP=5, AER_READY=1 -> words 0x0C9 then 0x0CB, both tagged 5. AER_VALID first seen at N+2. SPK_CNT=2.
- Back-to-back strobes: masks 1111, 0001, 0000 at bases 0, 4, 8 -> addresses 0, 1, 2, 3, 4 with no bubble between groups. The zero mask adds nothing. BUSY falls after the last handshake.
- Backpressure: AER_READY=0 for 10 cycles mid-group -> AER_ADDR is stable and AER_VALID stays high. Resume -> no loss and no duplicates.
- Overflow: AER_READY=0, 18 non-empty strobes with depth 16 -> 16 stored, DROP_CNT=2, OVF=1. Drain -> 16 groups emitted in order.
- Full with simultaneous pop and push: the push is accepted and DROP_CNT is unchanged.
- CLR mid-EMIT with 3 entries queued -> next cycle AER_VALID=0, BUSY=0, counters 0, and no stale words afterwards.
